// File: rtl/thread_fetch_scheduler.sv
// Fine-grained multithreading fetch scheduler: per-thread readiness tracking plus round-robin fetch grant.
// Optional macro SCHED_MISS_BLOCK_EN parks a thread in MISS_WAIT on an I-cache miss until its fill returns.

module thread_fetch_scheduler #(
    parameter int NUM_THREADS = 4,
    parameter int TID_W       = $clog2(NUM_THREADS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_stall,
    input  logic                   i_dec_valid,
    input  logic [TID_W-1:0]       i_dec_thread,
    input  logic                   i_dec_is_branch_jump,
    input  logic                   i_resolve_valid,
    input  logic [TID_W-1:0]       i_resolve_thread,
    input  logic                   i_miss_valid,
    input  logic [TID_W-1:0]       i_miss_thread,
    input  logic                   i_fill_valid,
    input  logic [TID_W-1:0]       i_fill_thread,
    input  logic                   i_done_valid,
    input  logic [TID_W-1:0]       i_done_thread,
    output logic                   o_valid,
    output logic [TID_W-1:0]       o_thread_id,
    output logic [NUM_THREADS-1:0] o_ready_mask,
    output logic                   o_all_done
);

    typedef enum logic [1:0] {
        READY,
        BR_WAIT,
        MISS_WAIT,
        DONE
    } threadState_e;

    threadState_e threadState_q [NUM_THREADS];
    threadState_e threadState_d [NUM_THREADS];

    logic [NUM_THREADS-1:0] branchHit;
    logic [NUM_THREADS-1:0] resolveHit;
    logic [NUM_THREADS-1:0] missHit;
    logic [NUM_THREADS-1:0] fillHit;
    logic [NUM_THREADS-1:0] doneHit;
    logic [NUM_THREADS-1:0] readyNext;

    logic [TID_W-1:0] ptr_q;
    logic [TID_W-1:0] tid_q;
    logic             valid_q;
    logic [TID_W-1:0] grantThread;
    logic             grantFound;

    always_comb begin
        branchHit  = '0;
        resolveHit = '0;
        missHit    = '0;
        fillHit    = '0;
        doneHit    = '0;
        for (int t = 0; t < NUM_THREADS; t++) begin
            branchHit[t]  = i_dec_valid && i_dec_is_branch_jump && (i_dec_thread == TID_W'(t));
            resolveHit[t] = i_resolve_valid && (i_resolve_thread == TID_W'(t));
            doneHit[t]    = i_done_valid && (i_done_thread == TID_W'(t));
`ifdef SCHED_MISS_BLOCK_EN
            missHit[t]    = i_miss_valid && (i_miss_thread == TID_W'(t));
            fillHit[t]    = i_fill_valid && (i_fill_thread == TID_W'(t));
`endif
        end
    end

`ifndef SCHED_MISS_BLOCK_EN
    // Misses go through the global stall path in this build, so these inputs are deliberately dropped.
    logic unusedMissInputs;
    assign unusedMissInputs = ^{i_miss_valid, i_miss_thread, i_fill_valid, i_fill_thread};
`endif

    // Done beats blocking, blocking beats unblocking; events outside the matching wait state are ignored.
    always_comb begin
        readyNext = '0;
        for (int t = 0; t < NUM_THREADS; t++) begin
            threadState_d[t] = threadState_q[t];
            if (doneHit[t]) begin
                threadState_d[t] = DONE;
            end else begin
                case (threadState_q[t])
                    READY: begin
                        if (branchHit[t]) begin
                            threadState_d[t] = BR_WAIT;
                        end else if (missHit[t]) begin
                            threadState_d[t] = MISS_WAIT;
                        end
                    end
                    BR_WAIT: begin
                        if (resolveHit[t]) begin
                            threadState_d[t] = READY;
                        end
                    end
                    MISS_WAIT: begin
                        if (fillHit[t]) begin
                            threadState_d[t] = READY;
                        end
                    end
                    default: begin
                    end
                endcase
            end
            readyNext[t] = (threadState_d[t] == READY);
        end
    end

    // Arbitrate on next-cycle readiness so a thread blocked this edge is never granted next cycle.
    always_comb begin
        grantFound  = 1'b0;
        grantThread = tid_q;
        for (int k = 1; k <= NUM_THREADS; k++) begin
            if (!grantFound && readyNext[ptr_q + TID_W'(k)]) begin
                grantFound  = 1'b1;
                grantThread = ptr_q + TID_W'(k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                threadState_q[t] <= READY;
            end
            ptr_q   <= TID_W'(NUM_THREADS - 1);
            tid_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            threadState_q <= threadState_d;
            if (!i_stall) begin
                if (grantFound) begin
                    valid_q <= 1'b1;
                    tid_q   <= grantThread;
                    ptr_q   <= grantThread;
                end else begin
                    valid_q <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        o_ready_mask = '0;
        o_all_done   = 1'b1;
        for (int t = 0; t < NUM_THREADS; t++) begin
            o_ready_mask[t] = (threadState_q[t] == READY);
            if (threadState_q[t] != DONE) begin
                o_all_done = 1'b0;
            end
        end
    end

    assign o_valid     = valid_q;
    assign o_thread_id = tid_q;

endmodule

// File: tb/tb_thread_fetch_scheduler.sv
// Self-checking bench for thread_fetch_scheduler: directed scenarios plus randomized traffic vs a reference model.
// Honours SCHED_MISS_BLOCK_EN the same way the design does.

module tb_thread_fetch_scheduler;

    localparam int N  = 4;
    localparam int TW = 2;
`ifdef SCHED_MISS_BLOCK_EN
    localparam bit MISS_EN = 1'b1;
`else
    localparam bit MISS_EN = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          i_stall;
    logic          i_dec_valid;
    logic [TW-1:0] i_dec_thread;
    logic          i_dec_is_branch_jump;
    logic          i_resolve_valid;
    logic [TW-1:0] i_resolve_thread;
    logic          i_miss_valid;
    logic [TW-1:0] i_miss_thread;
    logic          i_fill_valid;
    logic [TW-1:0] i_fill_thread;
    logic          i_done_valid;
    logic [TW-1:0] i_done_thread;
    logic          o_valid;
    logic [TW-1:0] o_thread_id;
    logic [N-1:0]  o_ready_mask;
    logic          o_all_done;

    int checks   = 0;
    int failures = 0;

    // Reference model: 0=ready, 1=branch wait, 2=miss wait, 3=done
    int mState [N];
    int mPtr;
    int mValid;
    int mTid;

    thread_fetch_scheduler #(.NUM_THREADS(N)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .i_stall              (i_stall),
        .i_dec_valid          (i_dec_valid),
        .i_dec_thread         (i_dec_thread),
        .i_dec_is_branch_jump (i_dec_is_branch_jump),
        .i_resolve_valid      (i_resolve_valid),
        .i_resolve_thread     (i_resolve_thread),
        .i_miss_valid         (i_miss_valid),
        .i_miss_thread        (i_miss_thread),
        .i_fill_valid         (i_fill_valid),
        .i_fill_thread        (i_fill_thread),
        .i_done_valid         (i_done_valid),
        .i_done_thread        (i_done_thread),
        .o_valid              (o_valid),
        .o_thread_id          (o_thread_id),
        .o_ready_mask         (o_ready_mask),
        .o_all_done           (o_all_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic setIdle();
        i_stall              = 1'b0;
        i_dec_valid          = 1'b0;
        i_dec_thread         = '0;
        i_dec_is_branch_jump = 1'b0;
        i_resolve_valid      = 1'b0;
        i_resolve_thread     = '0;
        i_miss_valid         = 1'b0;
        i_miss_thread        = '0;
        i_fill_valid         = 1'b0;
        i_fill_thread        = '0;
        i_done_valid         = 1'b0;
        i_done_thread        = '0;
    endtask

    // Advance the model by the rules using the inputs the DUT is about to sample.
    task automatic modelStep();
        int nxt [N];
        int found;
        if (!rst_n) begin
            for (int t = 0; t < N; t++) mState[t] = 0;
            mPtr   = N - 1;
            mValid = 0;
            mTid   = 0;
        end else begin
            for (int t = 0; t < N; t++) begin
                nxt[t] = mState[t];
                if (i_done_valid && int'(i_done_thread) == t) nxt[t] = 3;
                else if (mState[t] == 0 && i_dec_valid && i_dec_is_branch_jump && int'(i_dec_thread) == t) nxt[t] = 1;
                else if (mState[t] == 0 && MISS_EN && i_miss_valid && int'(i_miss_thread) == t) nxt[t] = 2;
                else if (mState[t] == 1 && i_resolve_valid && int'(i_resolve_thread) == t) nxt[t] = 0;
                else if (mState[t] == 2 && MISS_EN && i_fill_valid && int'(i_fill_thread) == t) nxt[t] = 0;
            end
            if (!i_stall) begin
                found = -1;
                for (int k = 1; k <= N; k++) begin
                    if (found < 0 && nxt[(mPtr + k) % N] == 0) found = (mPtr + k) % N;
                end
                if (found >= 0) begin
                    mValid = 1;
                    mTid   = found;
                    mPtr   = found;
                end else begin
                    mValid = 0;
                end
            end
            for (int t = 0; t < N; t++) mState[t] = nxt[t];
        end
    endtask

    task automatic tick();
        modelStep();
        @(posedge clk);
        #1;
    endtask

    task automatic resetAndRelease();
        setIdle();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        setIdle();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if (o_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_valid got=%0b exp=0", o_valid);
        end
        checks++;
        if (o_thread_id !== 2'd0) begin
            failures++;
            $display("[TB] FAIL reset_tid got=%0d exp=0", o_thread_id);
        end
        checks++;
        if (o_ready_mask !== 4'b1111 || o_all_done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_mask got=%b/%b exp=1111/0", o_ready_mask, o_all_done);
        end
    endtask

    task automatic test_rotation();
        int expTid [6] = '{0, 1, 2, 3, 0, 1};
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (o_valid !== 1'b1 || int'(o_thread_id) != expTid[i]) begin
                failures++;
                $display("[TB] FAIL rotation[%0d] got=%0b/%0d exp=1/%0d", i, o_valid, o_thread_id, expTid[i]);
            end
        end
    endtask

    task automatic test_branch_wait();
        int expTid [3] = '{2, 3, 0};
        resetAndRelease();
        i_dec_valid          = 1'b1;
        i_dec_is_branch_jump = 1'b1;
        i_dec_thread         = 2'd1;
        for (int i = 0; i < 3; i++) begin
            tick();
            setIdle();
            checks++;
            if (int'(o_thread_id) != expTid[i] || o_ready_mask !== 4'b1101) begin
                failures++;
                $display("[TB] FAIL branch_wait[%0d] got=%0d/%b exp=%0d/1101", i, o_thread_id, o_ready_mask, expTid[i]);
            end
        end
        i_resolve_valid  = 1'b1;
        i_resolve_thread = 2'd1;
        tick();
        setIdle();
        checks++;
        if (o_valid !== 1'b1 || o_thread_id !== 2'd1 || o_ready_mask !== 4'b1111) begin
            failures++;
            $display("[TB] FAIL branch_regrant got=%0b/%0d/%b exp=1/1/1111", o_valid, o_thread_id, o_ready_mask);
        end
    endtask

    task automatic test_miss_block();
        int blockThr [3] = '{0, 1, 3};
        resetAndRelease();
        i_dec_valid          = 1'b1;
        i_dec_is_branch_jump = 1'b1;
        for (int i = 0; i < 3; i++) begin
            i_dec_thread = blockThr[i][TW-1:0];
            if (i == 2) begin
                i_miss_valid  = 1'b1;
                i_miss_thread = 2'd2;
            end
            tick();
        end
        setIdle();
        tick();
`ifdef SCHED_MISS_BLOCK_EN
        checks++;
        if (o_valid !== 1'b0 || o_thread_id !== 2'd2 || o_ready_mask !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL miss_all_blocked got=%0b/%0d/%b exp=0/2/0000", o_valid, o_thread_id, o_ready_mask);
        end
        i_fill_valid  = 1'b1;
        i_fill_thread = 2'd2;
        tick();
        setIdle();
        checks++;
        if (o_valid !== 1'b1 || o_thread_id !== 2'd2) begin
            failures++;
            $display("[TB] FAIL miss_fill got=%0b/%0d exp=1/2", o_valid, o_thread_id);
        end
`else
        checks++;
        if (o_valid !== 1'b1 || o_thread_id !== 2'd2 || o_ready_mask !== 4'b0100) begin
            failures++;
            $display("[TB] FAIL miss_ignored got=%0b/%0d/%b exp=1/2/0100", o_valid, o_thread_id, o_ready_mask);
        end
`endif
    endtask

    task automatic test_stall();
        resetAndRelease();
        i_stall              = 1'b1;
        i_dec_valid          = 1'b1;
        i_dec_is_branch_jump = 1'b1;
        i_dec_thread         = 2'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            i_dec_valid = 1'b0;
            checks++;
            if (o_valid !== 1'b1 || o_thread_id !== 2'd0 || o_ready_mask !== 4'b1110) begin
                failures++;
                $display("[TB] FAIL stall_hold[%0d] got=%0b/%0d/%b exp=1/0/1110", i, o_valid, o_thread_id, o_ready_mask);
            end
        end
        setIdle();
        tick();
        checks++;
        if (o_valid !== 1'b1 || o_thread_id !== 2'd1) begin
            failures++;
            $display("[TB] FAIL stall_release got=%0b/%0d exp=1/1", o_valid, o_thread_id);
        end
    endtask

    task automatic test_same_cycle_and_done();
        resetAndRelease();
        i_dec_valid          = 1'b1;
        i_dec_is_branch_jump = 1'b1;
        i_dec_thread         = 2'd3;
        i_resolve_valid      = 1'b1;
        i_resolve_thread     = 2'd3;
        tick();
        setIdle();
        checks++;
        if (o_ready_mask !== 4'b0111) begin
            failures++;
            $display("[TB] FAIL same_cycle_br got=%b exp=0111", o_ready_mask);
        end
        for (int t = 0; t < N; t++) begin
            i_done_valid  = 1'b1;
            i_done_thread = t[TW-1:0];
            tick();
        end
        setIdle();
        checks++;
        if (o_all_done !== 1'b1 || o_valid !== 1'b0 || o_ready_mask !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL all_done got=%0b/%0b/%b exp=1/0/0000", o_all_done, o_valid, o_ready_mask);
        end
        i_resolve_valid  = 1'b1;
        i_resolve_thread = 2'd3;
        tick();
        setIdle();
        checks++;
        if (o_all_done !== 1'b1 || o_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL done_sticky got=%0b/%0b exp=1/0", o_all_done, o_valid);
        end
    endtask

    task automatic test_reset_midop();
        resetAndRelease();
        i_dec_valid          = 1'b1;
        i_dec_is_branch_jump = 1'b1;
        i_dec_thread         = 2'd1;
        tick();
        i_dec_thread = 2'd2;
        tick();
        setIdle();
        checks++;
        if (o_ready_mask !== 4'b1001) begin
            failures++;
            $display("[TB] FAIL midop_wait got=%b exp=1001", o_ready_mask);
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if (o_ready_mask !== 4'b1111 || o_valid !== 1'b0 || o_thread_id !== 2'd0) begin
            failures++;
            $display("[TB] FAIL midop_reset got=%b/%0b/%0d exp=1111/0/0", o_ready_mask, o_valid, o_thread_id);
        end
        rst_n = 1'b1;
        i_resolve_valid  = 1'b1;
        i_resolve_thread = 2'd1;
        tick();
        setIdle();
        checks++;
        if (o_valid !== 1'b1 || o_thread_id !== 2'd0 || o_ready_mask !== 4'b1111) begin
            failures++;
            $display("[TB] FAIL midop_release got=%0b/%0d/%b exp=1/0/1111", o_valid, o_thread_id, o_ready_mask);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] expMask;
        logic         expDone;
        resetAndRelease();
        for (int c = 0; c < 400; c++) begin
            rst_n                = ($urandom_range(0, 99) != 0);
            i_stall              = ($urandom_range(0, 4) == 0);
            i_dec_valid          = $urandom_range(0, 1) == 1;
            i_dec_is_branch_jump = ($urandom_range(0, 2) == 0);
            i_dec_thread         = TW'($urandom_range(0, N - 1));
            i_resolve_valid      = ($urandom_range(0, 2) == 0);
            i_resolve_thread     = TW'($urandom_range(0, N - 1));
            i_miss_valid         = ($urandom_range(0, 5) == 0);
            i_miss_thread        = TW'($urandom_range(0, N - 1));
            i_fill_valid         = ($urandom_range(0, 2) == 0);
            i_fill_thread        = TW'($urandom_range(0, N - 1));
            i_done_valid         = ($urandom_range(0, 59) == 0);
            i_done_thread        = TW'($urandom_range(0, N - 1));
            tick();
            expDone = 1'b1;
            for (int t = 0; t < N; t++) begin
                expMask[t] = (mState[t] == 0);
                if (mState[t] != 3) expDone = 1'b0;
            end
            checks++;
            if (int'(o_valid) != mValid || int'(o_thread_id) != mTid || o_ready_mask !== expMask || o_all_done !== expDone) begin
                failures++;
                $display("[TB] FAIL random[%0d] got=v%0b t%0d m%b d%0b exp=v%0d t%0d m%b d%0b",
                         c, o_valid, o_thread_id, o_ready_mask, o_all_done, mValid, mTid, expMask, expDone);
            end
        end
        setIdle();
        rst_n = 1'b1;
    endtask

    initial begin
        setIdle();
        rst_n = 1'b0;
        for (int t = 0; t < N; t++) mState[t] = 0;
        mPtr   = N - 1;
        mValid = 0;
        mTid   = 0;
        test_reset();
        test_rotation();
        test_branch_wait();
        test_miss_block();
        test_stall();
        test_same_cycle_and_done();
        test_reset_midop();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
